issue_scoreboard: RTL and testbench

Register scoreboard and issue controller for the decode stage. Tracks destination registers of issued long-latency instructions (loads) until their writeback. Stalls the instruction in decode on RAW/WAW hazards against those registers, on a full outstanding-write budget, and on fences until all pending writes drain. Sits beside the decode stage, fed by decode fields and by the writeback port that drives the register file.

---
 rtl/common.sv | 13 +
 rtl/issue_scoreboard_watchdog.sv | 34 +++
 rtl/issue_scoreboard.sv | 112 +++++++++++
 tb/tb_issue_scoreboard.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared decode-stage types and constants used by the issue scoreboard.
package common;

    localparam int REGISTER_FILE_SIZE     = 32;
    localparam int REG_ID_W               = $clog2(REGISTER_FILE_SIZE);
    localparam int SB_MAX_PENDING_DEFAULT = 4;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_type;

endpackage

// File: rtl/issue_scoreboard_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky flag at LIMIT.
// Instantiated by issue_scoreboard only when SCOREBOARD_TIMEOUT_EN is defined.
module sb_watchdog #(
    parameter int  LIMIT = 1024,
    localparam int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    output logic timeout
);

    localparam logic [CW-1:0] LIMIT_CNT = CW'(LIMIT);

    logic [CW-1:0] cnt_q;

    // The flag rises on the same edge the counter reaches the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            if (!stall) begin
                cnt_q <= '0;
            end else if (cnt_q != LIMIT_CNT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (stall && (cnt_q >= LIMIT_CNT - CW'(1))) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue controller beside decode: tracks pending load
// destinations, stalls on RAW/WAW, budget and fence drain. Optional watchdog: SCOREBOARD_TIMEOUT_EN.
module issue_scoreboard
    import common::*;
#(
    parameter int  MAX_PENDING    = SB_MAX_PENDING_DEFAULT,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int CNT_W          = $clog2(MAX_PENDING + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          dec_valid,
    input  logic [REG_ID_W-1:0]           dec_rs1_id,
    input  logic [REG_ID_W-1:0]           dec_rs2_id,
    input  logic                          dec_rs1_used,
    input  logic                          dec_rs2_used,
    input  logic [REG_ID_W-1:0]           dec_rd_id,
    input  logic                          dec_rd_write,
    input  logic                          dec_long_lat,
    input  logic                          dec_fence,
    input  logic                          flush,
    input  logic                          wb_en,
    input  logic [REG_ID_W-1:0]           wb_id,
    output logic                          stall,
    output logic                          issue,
    output logic [REGISTER_FILE_SIZE-1:0] busy_mask,
    output logic [CNT_W-1:0]              pending_count,
    output logic                          sb_timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    sb_state_type                  state_q, state_d;
    logic [REGISTER_FILE_SIZE-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          hazard, budget_stall, fence_wait;
    logic                          set_busy, clr_busy;

    // Busy bit 0 is never set, so x0 can never raise a hazard.
    assign hazard = dec_valid & ((dec_rs1_used & busy_q[dec_rs1_id]) |
                                 (dec_rs2_used & busy_q[dec_rs2_id]) |
                                 (dec_rd_write & busy_q[dec_rd_id]));

    assign budget_stall = dec_valid & dec_rd_write & dec_long_lat &
                          (dec_rd_id != '0) & (count_q == MAX_CNT);

    assign fence_wait = dec_valid & dec_fence & (count_q != '0);

    // Gating with reset_n keeps issue quiet while decode inputs are undefined in reset.
    assign stall = reset_n & ~flush &
                   (hazard | budget_stall | fence_wait | (state_q == SB_DRAIN));
    assign issue = reset_n & dec_valid & ~flush & ~stall;

    assign set_busy = issue & dec_rd_write & dec_long_lat & (dec_rd_id != '0);
    assign clr_busy = wb_en & busy_q[wb_id];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        state_d = state_q;

        if (set_busy) busy_d[dec_rd_id] = 1'b1;
        if (clr_busy) busy_d[wb_id]     = 1'b0;

        // A WAW stall blocks setting a busy id, so set and clear never hit the same bit.
        case ({set_busy, clr_busy})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            SB_RUN:   if (dec_valid && dec_fence && !flush && count_q != '0) state_d = SB_DRAIN;
            SB_DRAIN: if (count_q == '0 || flush) state_d = SB_RUN;
            default:  state_d = SB_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SB_RUN;
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_mask     = busy_q;
    assign pending_count = count_q;

`ifdef SCOREBOARD_TIMEOUT_EN
    sb_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (stall),
        .timeout (sb_timeout)
    );
`else
    // The limit is meaningless without the watchdog; fold it into an ignored net.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign sb_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: stimulus pushes model expectations, a negedge monitor compares.
module tb_issue_scoreboard;

    localparam int MAXP = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_write, dec_long_lat;
    logic        dec_fence, flush, wb_en;
    logic [4:0]  dec_rs1_id, dec_rs2_id, dec_rd_id, wb_id;
    logic        stall, issue, sb_timeout;
    logic [31:0] busy_mask;
    logic [2:0]  pending_count;

    always #5 clk = ~clk;

    issue_scoreboard #(
        .MAX_PENDING    (MAXP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dec_valid     (dec_valid),
        .dec_rs1_id    (dec_rs1_id),
        .dec_rs2_id    (dec_rs2_id),
        .dec_rs1_used  (dec_rs1_used),
        .dec_rs2_used  (dec_rs2_used),
        .dec_rd_id     (dec_rd_id),
        .dec_rd_write  (dec_rd_write),
        .dec_long_lat  (dec_long_lat),
        .dec_fence     (dec_fence),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_id         (wb_id),
        .stall         (stall),
        .issue         (issue),
        .busy_mask     (busy_mask),
        .pending_count (pending_count),
        .sb_timeout    (sb_timeout)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       rs1u;
        logic [4:0] rs2;
        logic       rs2u;
        logic [4:0] rd;
        logic       rdw;
        logic       ll;
        logic       fence;
        logic       flush;
        logic       wb;
        logic [4:0] wbid;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic [31:0] busy;
        logic [2:0]  count;
        logic        timeout;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    stim_t rs;
    int    n_pass = 0;
    int    n_total = 0;

    // Reference model: list of outstanding load destinations plus fence-drain and watchdog state.
    int pend_q[$];
    bit draining = 0;
    int stall_run = 0;
    bit timeout_flag = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    function automatic bit is_pending(input int id);
        foreach (pend_q[i]) if (pend_q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (pend_q[i]) m[pend_q[i]] = 1'b1;
        return m;
    endfunction

    function automatic stim_t mk_nop();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t mk_load(input int rd);
        stim_t s = '0;
        s.v = 1'b1; s.rd = 5'(rd); s.rdw = 1'b1; s.ll = 1'b1;
        return s;
    endfunction

    function automatic stim_t mk_add(input int rs1, input int rs2, input int rd);
        stim_t s = '0;
        s.v = 1'b1; s.rs1 = 5'(rs1); s.rs1u = 1'b1; s.rs2 = 5'(rs2); s.rs2u = 1'b1;
        s.rd = 5'(rd); s.rdw = 1'b1;
        return s;
    endfunction

    function automatic stim_t mk_fence();
        stim_t s = '0;
        s.v = 1'b1; s.fence = 1'b1;
        return s;
    endfunction

    function automatic stim_t with_wb(input stim_t base, input int id);
        stim_t s = base;
        s.wb = 1'b1; s.wbid = 5'(id);
        return s;
    endfunction

    // Apply one cycle of stimulus just after a rising edge and queue what the outputs must be.
    task automatic step(input stim_t s, input logic rst = 1'b1);
        exp_t e;
        bit   hz, bud, fw, st, iss;
        int   sz;
        reset_n      = rst;
        dec_valid    = s.v;     dec_rs1_id   = s.rs1;  dec_rs1_used = s.rs1u;
        dec_rs2_id   = s.rs2;   dec_rs2_used = s.rs2u; dec_rd_id    = s.rd;
        dec_rd_write = s.rdw;   dec_long_lat = s.ll;   dec_fence    = s.fence;
        flush        = s.flush; wb_en        = s.wb;   wb_id        = s.wbid;
        e = '0;
        if (!rst) begin
            pend_q.delete();
            draining = 0; stall_run = 0; timeout_flag = 0;
        end else begin
            sz  = pend_q.size();
            hz  = s.v && ((s.rs1u && is_pending(int'(s.rs1))) ||
                          (s.rs2u && is_pending(int'(s.rs2))) ||
                          (s.rdw  && is_pending(int'(s.rd))));
            bud = s.v && s.rdw && s.ll && s.rd != 0 && sz == MAXP;
            fw  = s.v && s.fence && sz != 0;
            st  = !s.flush && (hz || bud || fw || draining);
            iss = s.v && !s.flush && !st;
            e.stall = st;
            e.issue = iss;
            e.busy  = model_mask();
            e.count = 3'(sz);
`ifdef SCOREBOARD_TIMEOUT_EN
            e.timeout = timeout_flag;
`endif
            if (s.wb) begin
                for (int i = 0; i < pend_q.size(); i++) begin
                    if (pend_q[i] == int'(s.wbid)) begin
                        pend_q.delete(i);
                        break;
                    end
                end
            end
            if (iss && s.rdw && s.ll && s.rd != 0) pend_q.push_back(int'(s.rd));
            if (draining) draining = !(sz == 0 || s.flush);
            else          draining = s.v && s.fence && !s.flush && sz != 0;
            if (st) begin
                if (stall_run < TMO) stall_run++;
                if (stall_run == TMO) timeout_flag = 1;
            end else begin
                stall_run = 0;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("stall",         32'(stall),         32'(mon_e.stall));
            check("issue",         32'(issue),         32'(mon_e.issue));
            check("busy_mask",     busy_mask,          mon_e.busy);
            check("pending_count", 32'(pending_count), 32'(mon_e.count));
            check("sb_timeout",    32'(sb_timeout),    32'(mon_e.timeout));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL time_limit: got no finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        rs = '0;
        dec_valid = 0; dec_rs1_id = 0; dec_rs2_id = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd_id = 0; dec_rd_write = 0; dec_long_lat = 0; dec_fence = 0; flush = 0;
        wb_en = 0; wb_id = 0;
        @(posedge clk);
        #1;
        // Reset state, with a valid hazard-free instruction presented during reset.
        step(mk_load(3), 1'b0);
        step(mk_nop(), 1'b0);

        // Load-use: consumer stalls until the cycle after writeback.
        step(mk_load(5));
        step(mk_add(5, 0, 7));
        step(mk_add(5, 0, 7));
        step(with_wb(mk_add(5, 0, 7), 5));
        step(mk_add(5, 0, 7));
        step(mk_nop());

        // Budget and WAW.
        for (int r = 1; r <= 4; r++) step(mk_load(r));
        step(mk_load(6));
        step(with_wb(mk_load(6), 2));
        step(mk_load(6));
        step(mk_load(3));
        step(with_wb(mk_load(3), 1));
        step(with_wb(mk_nop(), 3));
        step(with_wb(mk_nop(), 4));
        step(with_wb(mk_nop(), 6));

        // Fence drain.
        step(mk_load(8));
        step(mk_load(9));
        step(mk_fence());
        step(mk_fence());
        step(with_wb(mk_fence(), 8));
        step(with_wb(mk_fence(), 9));
        step(mk_fence());
        step(mk_fence());
        step(mk_fence());

        // Flush, x0 destination, spurious writeback.
        step(mk_load(10));
        rs = mk_add(10, 10, 11);
        rs.flush = 1'b1;
        step(rs);
        step(mk_load(0));
        step(with_wb(mk_nop(), 9));
        step(with_wb(mk_nop(), 0));
        step(with_wb(mk_nop(), 10));

        // Reset while draining with three pending loads.
        step(mk_load(11));
        step(mk_load(12));
        step(mk_load(13));
        step(mk_fence());
        step(mk_fence());
        step(mk_fence(), 1'b0);
        step(mk_fence());
        step(mk_add(11, 12, 13));

        // Watchdog: hold a RAW hazard past the limit, then release it.
        step(mk_load(14));
        for (int i = 0; i < TMO + 4; i++) step(mk_add(14, 0, 15));
        step(with_wb(mk_add(14, 0, 15), 14));
        step(mk_add(14, 0, 15));
        for (int i = 0; i < 3; i++) step(mk_nop());
        step(mk_nop(), 1'b0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            rs       = '0;
            rs.v     = ($urandom_range(0, 3) != 0);
            rs.rs1   = 5'($urandom_range(0, 7));
            rs.rs1u  = 1'($urandom_range(0, 1));
            rs.rs2   = 5'($urandom_range(0, 7));
            rs.rs2u  = 1'($urandom_range(0, 1));
            rs.rd    = 5'($urandom_range(0, 7));
            rs.rdw   = 1'($urandom_range(0, 1));
            rs.ll    = 1'($urandom_range(0, 1));
            rs.fence = ($urandom_range(0, 19) == 0);
            rs.flush = ($urandom_range(0, 9) == 0);
            rs.wb    = ($urandom_range(0, 2) == 0);
            if (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
                rs.wbid = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            else
                rs.wbid = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 499) == 0) step(rs, 1'b0);
            else                             step(rs);
        end

        step(mk_nop());
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
